ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 154 +++++++++++++++
 tb/tb_ifetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding memory request feeding a 2-entry {inst, pc} FIFO, with redirect flush.
// Define IFU_BYPASS_EN to forward acked data straight to the decode outputs while the FIFO is empty.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [4:0]  opcode
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] pend_pc;
    logic [31:0] word_q [2];
    logic [31:0] pc_q   [2];
    logic [1:0]  count;

    logic [31:0] target_pc;
    logic        fifo_pop;
    logic        push;
    logic        bypass_hit;
    logic        bypass_take;
    logic [1:0]  next_count;

    assign target_pc = redirect_pc & ~32'd3;
    assign fifo_pop  = (count != 2'd0) && inst_ready;

`ifdef IFU_BYPASS_EN
    assign bypass_hit = (state == REQ) && imem_ack && !redirect && (count == 2'd0);
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed word consumed by decode in the same cycle never enters the FIFO.
    assign bypass_take = bypass_hit && inst_ready;
    assign push        = (state == REQ) && imem_ack && !redirect && !bypass_take;

    always_comb begin
        next_count = count;
        if (push && !fifo_pop) begin
            next_count = count + 2'd1;
        end else if (!push && fifo_pop) begin
            next_count = count - 2'd1;
        end
    end

    assign imem_req   = (state != IDLE);
    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != 2'd0) || bypass_hit;
    assign inst       = bypass_hit ? imem_rdata : word_q[0];
    assign inst_pc    = bypass_hit ? fetch_pc : pc_q[0];
    assign opcode     = inst[6:2];

    // FIFO storage: slot 0 is always the head.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count     <= 2'd0;
            word_q[0] <= 32'd0;
            word_q[1] <= 32'd0;
            pc_q[0]   <= 32'd0;
            pc_q[1]   <= 32'd0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            if (fifo_pop && push) begin
                if (count == 2'd1) begin
                    word_q[0] <= imem_rdata;
                    pc_q[0]   <= fetch_pc;
                end else begin
                    word_q[0] <= word_q[1];
                    pc_q[0]   <= pc_q[1];
                    word_q[1] <= imem_rdata;
                    pc_q[1]   <= fetch_pc;
                end
            end else if (fifo_pop) begin
                word_q[0] <= word_q[1];
                pc_q[0]   <= pc_q[1];
            end else if (push) begin
                if (count == 2'd0) begin
                    word_q[0] <= imem_rdata;
                    pc_q[0]   <= fetch_pc;
                end else begin
                    word_q[1] <= imem_rdata;
                    pc_q[1]   <= fetch_pc;
                end
            end
            count <= next_count;
        end
    end

    // Request FSM; in FLUSH, fetch_pc keeps the stale address until its ack and pend_pc holds the restart target.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            pend_pc  <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= target_pc;
                        state    <= REQ;
                    end else if (next_count < 2'd2) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            fetch_pc <= target_pc;
                        end else begin
                            pend_pc <= target_pc;
                            state   <= FLUSH;
                        end
                    end else if (imem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= (next_count < 2'd2) ? REQ : IDLE;
                    end
                end
                FLUSH: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            fetch_pc <= target_pc;
                            state    <= REQ;
                        end else begin
                            pend_pc <= target_pc;
                        end
                    end else if (imem_ack) begin
                        fetch_pc <= pend_pc;
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized and directed bench for ifetch_unit, checked against a queue-based model of the fetch rules.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [4:0]  opcode;

    ifetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .opcode      (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    entry_t      m_q[$];
    bit          m_out;
    bit          m_discard;
    logic [31:0] m_addr;
    logic [31:0] m_pend;

    int check_count = 0;
    int pass_count  = 0;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_inst;
    logic [31:0] s_pc;
    logic [4:0]  s_op;
    logic [31:0] seen_pc[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle, compare against the model before the edge, then advance the model across the edge.
    task automatic applyStimulus(input bit r, input bit ack, input logic [31:0] rdata,
                                 input bit rd, input logic [31:0] rpc, input bit rdy);
        bit          byp;
        bit          exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        bit          pop;
        entry_t      e;
        @(negedge clk);
        rst         = r;
        imem_ack    = ack;
        imem_rdata  = rdata;
        redirect    = rd;
        redirect_pc = rpc;
        inst_ready  = rdy;
        #1;
        byp = 1'b0;
`ifdef IFU_BYPASS_EN
        byp = m_out && !m_discard && ack && !rd && (m_q.size() == 0);
`endif
        exp_valid = byp || (m_q.size() > 0);
        exp_inst  = byp ? rdata : (m_q.size() > 0 ? m_q[0].word : 32'd0);
        exp_pc    = byp ? m_addr : (m_q.size() > 0 ? m_q[0].pc : 32'd0);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = inst_valid;
        s_inst  = inst;
        s_pc    = inst_pc;
        s_op    = opcode;
        if (inst_valid) seen_pc.push_back(inst_pc);
        checkOutput("imem_req", {31'd0, imem_req}, {31'd0, m_out});
        checkOutput("imem_addr", imem_addr, m_addr);
        checkOutput("inst_valid", {31'd0, inst_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            checkOutput("inst", inst, exp_inst);
            checkOutput("inst_pc", inst_pc, exp_pc);
            checkOutput("opcode", {27'd0, opcode}, {27'd0, exp_inst[6:2]});
        end
        @(posedge clk);
        if (!r) begin
            m_q.delete();
            m_out     = 1'b0;
            m_discard = 1'b0;
            m_addr    = RST_PC;
        end else if (rd) begin
            m_q.delete();
            if (m_out && !ack) begin
                m_discard = 1'b1;
                m_pend    = rpc & ~32'd3;
            end else begin
                m_addr    = rpc & ~32'd3;
                m_discard = 1'b0;
                m_out     = 1'b1;
            end
        end else if (m_out && ack && m_discard) begin
            m_addr    = m_pend;
            m_discard = 1'b0;
        end else begin
            pop = (m_q.size() > 0) && rdy;
            if (pop) void'(m_q.pop_front());
            if (m_out && ack) begin
                if (!(byp && rdy)) begin
                    e.word = rdata;
                    e.pc   = m_addr;
                    m_q.push_back(e);
                end
                m_addr = m_addr + 32'd4;
            end
            if (!m_out || ack) m_out = (m_q.size() < 2);
        end
    endtask

    initial begin
        m_out = 1'b0; m_discard = 1'b0; m_addr = RST_PC; m_pend = RST_PC;
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        redirect = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;

        // Reset values
        applyStimulus(0, 0, 32'd0, 0, 32'd0, 0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0, 0);
        checkOutput("rst_req", {31'd0, s_req}, 32'd0);
        checkOutput("rst_addr", s_addr, RST_PC);
        checkOutput("rst_valid", {31'd0, s_valid}, 32'd0);
        checkOutput("rst_inst", s_inst, 32'd0);
        checkOutput("rst_pc", s_pc, 32'd0);
        checkOutput("rst_op", {27'd0, s_op}, 32'd0);

        // Release and stream with ack/ready every cycle
        applyStimulus(1, 0, 32'd0, 0, 32'd0, 1);
        seen_pc.delete();
        applyStimulus(1, 1, $urandom(), 0, 32'd0, 1);
        checkOutput("rel_req", {31'd0, s_req}, 32'd1);
        checkOutput("rel_addr", s_addr, RST_PC);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, $urandom(), 0, 32'd0, 1);
        for (int i = 0; i < 4; i++)
            checkOutput("stream_pc", (seen_pc.size() > i) ? seen_pc[i] : 32'hxxxx_xxxx, 32'(i * 4));

        // Random traffic, including occasional mid-request resets
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit a;
            r = ($urandom_range(0, 49) != 0);
            a = r ? (m_out && ($urandom_range(0, 9) < 6)) : $urandom_range(0, 1) == 1;
            applyStimulus(r, a, $urandom(), $urandom_range(0, 9) == 0, $urandom(), $urandom_range(0, 1) == 1);
        end

        // Back-pressure: two words buffered, request stops, one pop restarts it
        applyStimulus(1, m_out, 32'd0, 1, 32'h0000_0200, 0);
        applyStimulus(1, 1, 32'h1111_1113, 0, 32'd0, 0);
        applyStimulus(1, 1, 32'h2222_2227, 0, 32'd0, 0);
        applyStimulus(1, 0, 32'd0, 0, 32'd0, 0);
        checkOutput("full_req", {31'd0, s_req}, 32'd0);
        checkOutput("full_head", s_pc, 32'h0000_0200);
        applyStimulus(1, 0, 32'd0, 0, 32'd0, 1);
        applyStimulus(1, 0, 32'd0, 0, 32'd0, 0);
        checkOutput("refill_req", {31'd0, s_req}, 32'd1);
        checkOutput("refill_addr", s_addr, 32'h0000_0208);

        // Redirect while a request is outstanding: late ack is dropped
        applyStimulus(1, 0, 32'd0, 1, 32'h0000_0103, 0);
        applyStimulus(1, 0, 32'd0, 0, 32'd0, 0);
        checkOutput("flush_hold", s_addr, 32'h0000_0208);
        applyStimulus(1, 1, 32'hDEAD_BEEF, 0, 32'd0, 0);
        checkOutput("flush_ack_valid", {31'd0, s_valid}, 32'd0);
        applyStimulus(1, 0, 32'd0, 0, 32'd0, 0);
        checkOutput("flush_addr", s_addr, 32'h0000_0100);
        checkOutput("flush_empty", {31'd0, s_valid}, 32'd0);

        // Redirect and ack together
        applyStimulus(1, 1, 32'hBEEF_0003, 1, 32'h0000_0300, 0);
        applyStimulus(1, 0, 32'd0, 0, 32'd0, 0);
        checkOutput("rd_ack_addr", s_addr, 32'h0000_0300);
        checkOutput("rd_ack_empty", {31'd0, s_valid}, 32'd0);

        // Address wrap
        applyStimulus(1, 1, 32'd0, 1, 32'hFFFF_FFFC, 1);
        applyStimulus(1, 1, 32'h0000_0013, 0, 32'd0, 1);
        applyStimulus(1, 0, 32'd0, 0, 32'd0, 1);
        checkOutput("wrap_addr", s_addr, 32'h0000_0000);

        // Ack into an empty FIFO
        applyStimulus(1, 1, 32'h0000_0033, 0, 32'd0, 1);
`ifdef IFU_BYPASS_EN
        checkOutput("byp_valid", {31'd0, s_valid}, 32'd1);
        checkOutput("byp_op", {27'd0, s_op}, 32'h0000_000C);
`else
        checkOutput("nobyp_valid", {31'd0, s_valid}, 32'd0);
        applyStimulus(1, 0, 32'd0, 0, 32'd0, 1);
        checkOutput("nobyp_valid_next", {31'd0, s_valid}, 32'd1);
        checkOutput("nobyp_op", {27'd0, s_op}, 32'h0000_000C);
`endif

        // Reset during a request; an ack under reset is ignored
        applyStimulus(0, 0, 32'd0, 0, 32'd0, 0);
        applyStimulus(0, 1, 32'h0000_1234, 0, 32'd0, 0);
        applyStimulus(1, 0, 32'd0, 0, 32'd0, 0);
        applyStimulus(1, 0, 32'd0, 0, 32'd0, 0);
        checkOutput("rst_mid_valid", {31'd0, s_valid}, 32'd0);
        checkOutput("rst_mid_addr", s_addr, RST_PC);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
